fwd_hazard_unit: RTL and testbench

- Parametrised successor to the two-port MEM/WB forwarding mux selector.
- Generalises forwarding to NRD read ports.
- Adds load-use stall detection and a per-register scoreboard with countdown counters for multi-cycle (mul/div) results.
- Adds a saturating stall-cycle performance counter.
- Sits beside the ID/EX pipeline register: consumes ID source registers and EX/MEM/WB destination info, drives operand-mux selects and the pipeline stall.

---
 rtl/fwd_hazard_unit.sv | 108 ++++++++++
 tb/tb_fwd_hazard_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects, load-use / multi-cycle stall detection and a stall counter.
// Sits beside the ID/EX pipeline register.
module fwd_hazard_unit #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned NRD    = 2,
    parameter int unsigned LAT_W  = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [NRD*REG_AW-1:0] id_rs,
    input  logic [NRD-1:0]        id_rs_used,
    input  logic [REG_AW-1:0]     ex_rd,
    input  logic                  ex_rw,
    input  logic                  ex_is_load,
    input  logic [REG_AW-1:0]     mem_rd,
    input  logic                  mem_rw,
    input  logic [REG_AW-1:0]     wb_rd,
    input  logic                  wb_rw,
    input  logic                  mc_issue,
    input  logic [REG_AW-1:0]     mc_rd,
    input  logic [LAT_W-1:0]      mc_lat,
    input  logic                  flush,
    output logic [NRD*2-1:0]      fwd_sel,
    output logic                  stall,
    output logic                  sb_busy,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int unsigned NREG = 2 ** REG_AW;

    logic [LAT_W-1:0] cnt_q [NREG];
    logic [LAT_W-1:0] cnt_d [NREG];
    logic [CNT_W-1:0] stall_cycles_q;
    logic             load_use;
    logic             sb_hit;

    always_comb begin
        fwd_sel = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            logic [REG_AW-1:0] rs;
            rs = id_rs[i*REG_AW +: REG_AW];
            if (mem_rw && mem_rd != '0 && rs == mem_rd) begin
                fwd_sel[i*2 +: 2] = 2'b01;
            end else if (wb_rw && wb_rd != '0 && rs == wb_rd) begin
                fwd_sel[i*2 +: 2] = 2'b10;
            end
        end
    end

    // cnt==1 means the result is already on the WB path and forwardable, so only >1 stalls.
    always_comb begin
        load_use = 1'b0;
        sb_hit   = 1'b0;
        for (int unsigned i = 0; i < NRD; i++) begin
            logic [REG_AW-1:0] rs;
            rs = id_rs[i*REG_AW +: REG_AW];
            if (id_rs_used[i]) begin
                if (ex_is_load && ex_rw && ex_rd != '0 && rs == ex_rd) begin
                    load_use = 1'b1;
                end
                if (cnt_q[rs] > LAT_W'(1)) begin
                    sb_hit = 1'b1;
                end
            end
        end
        stall = id_valid && !flush && (load_use || sb_hit);
    end

    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
        end
        if (mc_issue && mc_rd != '0 && mc_lat != '0) begin
            cnt_d[mc_rd] = mc_lat;
        end
        cnt_d[0] = '0;
    end

    always_comb begin
        sb_busy = 1'b0;
        for (int unsigned r = 0; r < NREG; r++) begin
            if (cnt_q[r] != '0) begin
                sb_busy = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cycles_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            if (stall && stall_cycles_q != '1) begin
                stall_cycles_q <= stall_cycles_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit; a second instance with a
// 3-bit stall counter exercises saturation.
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [4:0]  ex_rd, mem_rd, wb_rd, mc_rd;
    logic        ex_rw, ex_is_load, mem_rw, wb_rw, mc_issue, flush;
    logic [3:0]  mc_lat;

    logic [3:0]  fwd_sel, fwd_sel_s;
    logic        stall, stall_s, sb_busy, sb_busy_s;
    logic [31:0] stall_cycles;
    logic [2:0]  stall_cycles_s;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .ex_rd(ex_rd), .ex_rw(ex_rw), .ex_is_load(ex_is_load),
        .mem_rd(mem_rd), .mem_rw(mem_rw), .wb_rd(wb_rd), .wb_rw(wb_rw),
        .mc_issue(mc_issue), .mc_rd(mc_rd), .mc_lat(mc_lat), .flush(flush),
        .fwd_sel(fwd_sel), .stall(stall), .sb_busy(sb_busy), .stall_cycles(stall_cycles)
    );

    fwd_hazard_unit #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .ex_rd(ex_rd), .ex_rw(ex_rw), .ex_is_load(ex_is_load),
        .mem_rd(mem_rd), .mem_rw(mem_rw), .wb_rd(wb_rd), .wb_rw(wb_rw),
        .mc_issue(mc_issue), .mc_rd(mc_rd), .mc_lat(mc_lat), .flush(flush),
        .fwd_sel(fwd_sel_s), .stall(stall_s), .sb_busy(sb_busy_s),
        .stall_cycles(stall_cycles_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs = '0; id_rs_used = '0;
        ex_rd = 0; ex_rw = 0; ex_is_load = 0;
        mem_rd = 0; mem_rw = 0; wb_rd = 0; wb_rw = 0;
        mc_issue = 0; mc_rd = 0; mc_lat = 0; flush = 0;
    endtask

    initial begin
        idle();
        rst_n = 0;
        step(); step();
        rst_n = 1;
        #1;
        check("rst_stall", stall, 0);
        check("rst_busy", sb_busy, 0);
        check("rst_cycles", stall_cycles, 0);
        check("rst_fwd", fwd_sel, 0);

        // Forwarding priority
        id_rs = {5'd6, 5'd5}; mem_rw = 1; mem_rd = 5; wb_rw = 1; wb_rd = 5;
        #1 check("fwd_mem_prio", fwd_sel, 4'b0001);
        wb_rd = 6;
        #1 check("fwd_mem_wb", fwd_sel, 4'b1001);
        mem_rd = 6; wb_rd = 5;
        #1 check("fwd_swap", fwd_sel, 4'b0110);
        id_rs = '0; mem_rd = 0; wb_rd = 0;
        #1 check("fwd_r0", fwd_sel, 4'b0000);

        // Load-use
        idle(); step();
        id_valid = 1; id_rs = {5'd7, 5'd1}; id_rs_used = 2'b11;
        ex_is_load = 1; ex_rw = 1; ex_rd = 7;
        #1 check("lu_stall", stall, 1);
        check("lu_cnt0", stall_cycles, 0);
        step();
        check("lu_cnt1", stall_cycles, 1);
        id_rs_used = 2'b01;
        #1 check("lu_unused", stall, 0);
        id_rs_used = 2'b11; flush = 1;
        #1 check("lu_flush", stall, 0);
        flush = 0; ex_is_load = 0;
        #1 check("lu_notload", stall, 0);
        ex_is_load = 1; ex_rd = 0; id_rs = {5'd0, 5'd1};
        #1 check("lu_rd0", stall, 0);
        step();
        check("lu_cnt_hold", stall_cycles, 1);

        // Multi-cycle countdown on r9
        idle();
        mc_issue = 1; mc_rd = 9; mc_lat = 4;
        step();
        mc_issue = 0; id_valid = 1; id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
        #1 check("mc_c4", stall, 1);
        check("mc_busy", sb_busy, 1);
        step(); check("mc_c3", stall, 1);
        step(); check("mc_c2", stall, 1);
        step();
        wb_rd = 9; wb_rw = 1;
        #1 check("mc_c1", stall, 0);
        check("mc_c1_fwd", fwd_sel, 4'b0010);
        check("mc_c1_busy", sb_busy, 1);
        step();
        check("mc_c0_busy", sb_busy, 0);
        check("mc_cycles", stall_cycles, 4);

        // WAW re-issue
        idle();
        mc_issue = 1; mc_rd = 3; mc_lat = 5;
        step();
        mc_issue = 0;
        step();
        mc_issue = 1; mc_rd = 3; mc_lat = 2;
        step();
        mc_issue = 0; id_valid = 1; id_rs = {5'd0, 5'd3}; id_rs_used = 2'b01;
        #1 check("waw_stall", stall, 1);
        step(); check("waw_free", stall, 0);
        step(); check("waw_busy", sb_busy, 0);

        // Ignored issues
        idle();
        mc_issue = 1; mc_rd = 0; mc_lat = 5;
        step(); check("ign_rd0", sb_busy, 0);
        mc_rd = 12; mc_lat = 0;
        step(); check("ign_lat0", sb_busy, 0);

        // Reset mid-countdown, with a simultaneous issue
        idle();
        mc_issue = 1; mc_rd = 4; mc_lat = 8;
        step();
        mc_issue = 0; id_valid = 1; id_rs = {5'd0, 5'd4}; id_rs_used = 2'b01;
        #1 check("rm_stall", stall, 1);
        step();
        check("rm_cycles", stall_cycles, 6);
        rst_n = 0; mc_issue = 1;
        step();
        rst_n = 1; mc_issue = 0;
        #1 check("rm_busy", sb_busy, 0);
        check("rm_stall0", stall, 0);
        check("rm_cycles0", stall_cycles, 0);
        check("rm_sat0", stall_cycles_s, 0);

        // Saturation: 10 load-use stall cycles
        idle();
        id_valid = 1; id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10;
        ex_is_load = 1; ex_rw = 1; ex_rd = 7;
        for (int i = 0; i < 7; i++) step();
        check("sat_7", stall_cycles_s, 7);
        for (int i = 0; i < 3; i++) step();
        check("sat_hold", stall_cycles_s, 7);
        check("sat_wide", stall_cycles, 10);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
